// File: rtl/seq_booth_radix4_multiplier_if.sv
// Operand/result handshake bundle for the sequential radix-4 Booth multiplier.
interface seq_booth_radix4_multiplier_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               signed_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;

  modport master (
    output in_valid, multiplicand, multiplier, signed_mode, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, signed_mode, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/seq_booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier: retires one recoded digit per cycle,
// WIDTH/2+1 cycles per product, valid/ready handshake on both sides.
module seq_booth_radix4_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input logic                         clk,
  input logic                         rst,
  seq_booth_radix4_multiplier_if.slave bus
);

  localparam int unsigned NumDigits = WIDTH / 2 + 1;
  localparam int unsigned AccW      = 2 * WIDTH + 4;
  localparam int unsigned MplrW     = WIDTH + 3;
  localparam int unsigned CntW      = $clog2(NumDigits);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q, state_d;
  logic [AccW-1:0]    acc_q, acc_d;
  logic [AccW-1:0]    mcand_q, mcand_d;
  logic [AccW-1:0]    pp;
  logic [MplrW-1:0]   mplr_q, mplr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               a_sign, b_sign;

  // The multiplicand is kept pre-shifted by 2i and the multiplier pre-shifted
  // right by 2i, so the current digit is always mplr_q[2:0].
  always_comb begin
    a_sign = bus.signed_mode & bus.multiplicand[WIDTH-1];
    b_sign = bus.signed_mode & bus.multiplier[WIDTH-1];

    case (mplr_q[2:0])
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q << 1;
      3'b100:         pp = -(mcand_q << 1);
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          state_d = StCalc;
          acc_d   = '0;
          cnt_d   = '0;
          mcand_d = {{(AccW - WIDTH){a_sign}}, bus.multiplicand};
          // Extra low zero is the implicit b[-1] of the first Booth triplet.
          mplr_d  = {{2{b_sign}}, bus.multiplier, 1'b0};
        end
      end
      StCalc: begin
        acc_d   = acc_q + pp;
        mcand_d = mcand_q << 2;
        mplr_d  = mplr_q >> 2;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntW'(NumDigits - 1)) begin
          state_d   = StDone;
          product_d = acc_d[2*WIDTH-1:0];
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.product   = product_q;

endmodule

// File: tb/tb_seq_booth_radix4_multiplier.sv
// Self-checking bench: directed table and hand sequences at WIDTH=32, plus
// randomized WIDTH=8/16 instances checked against an arithmetic reference.
module tb_seq_booth_radix4_multiplier;

  logic clk;
  logic rst32;
  int   n_checks;
  int   n_pass;
  int   small_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_booth_radix4_multiplier_if #(.WIDTH(32)) b32 ();

  seq_booth_radix4_multiplier #(.WIDTH(32)) dut32 (
    .clk (clk),
    .rst (rst32),
    .bus (b32)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  // Exact product of w-bit operands, truncated to 2w bits.
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input int w, input logic sm);
    longint     sa, sb;
    logic [63:0] p;
    if (sm) begin
      sa = $signed(a << (64 - w)) >>> (64 - w);
      sb = $signed(b << (64 - w)) >>> (64 - w);
      p  = sa * sb;
    end else begin
      p = a * b;
    end
    if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] mask;
    logic [63:0] r;
    mask = (64'd1 << w) - 64'd1;
    r    = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'd1 << (w - 1);
      2:       return mask;
      3:       return 64'd1;
      default: return r & mask;
    endcase
  endfunction

  // Operands and in_valid are scrambled while busy; the result must not care.
  task automatic run_op32(input logic [31:0] a, input logic [31:0] b, input logic sm,
                          output logic [63:0] prod, output int lat);
    b32.in_valid     = 1'b1;
    b32.multiplicand = a;
    b32.multiplier   = b;
    b32.signed_mode  = sm;
    cyc();
    lat = 0;
    while (!b32.out_valid && lat < 40) begin
      b32.in_valid     = 1'($urandom_range(0, 1));
      b32.multiplicand = $urandom;
      b32.multiplier   = $urandom;
      b32.signed_mode  = 1'($urandom_range(0, 1));
      cyc();
      lat++;
    end
    prod          = b32.product;
    b32.in_valid  = 1'b0;
    b32.out_ready = 1'b1;
    cyc();
    b32.out_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sm;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [63:0] prod;
    logic [63:0] ra, rb;
    logic        rsm;
    int          lat;
    int          guard;

    vecs[0] = '{32'd7,         32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    vecs[4] = '{32'd0,         32'h1234_5678, 1'b1, 64'd0};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000};
    vecs[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000};
    vecs[7] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000};
    vecs[8] = '{32'h1234_5678, 32'd0,         1'b0, 64'd0};
    vecs[9] = '{32'd5,         32'd6,         1'b1, 64'd30};

    b32.in_valid     = 1'b0;
    b32.out_ready    = 1'b0;
    b32.multiplicand = '0;
    b32.multiplier   = '0;
    b32.signed_mode  = 1'b0;
    rst32 = 1'b1;
    cyc();
    cyc();
    rst32 = 1'b0;
    chk("reset in_ready", 64'(b32.in_ready), 64'd1);
    chk("reset out_valid", 64'(b32.out_valid), 64'd0);
    chk("reset product", b32.product, 64'd0);

    foreach (vecs[i]) begin
      run_op32(vecs[i].a, vecs[i].b, vecs[i].sm, prod, lat);
      chk($sformatf("vec%0d product", i), prod, vecs[i].exp);
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'd17);
      chk($sformatf("vec%0d in_ready after release", i), 64'(b32.in_ready), 64'd1);
    end

    for (int i = 0; i < 16; i++) begin
      ra  = pick(32);
      rb  = pick(32);
      rsm = 1'($urandom_range(0, 1));
      run_op32(ra[31:0], rb[31:0], rsm, prod, lat);
      chk($sformatf("rand32 %h*%h s=%0d", ra[31:0], rb[31:0], rsm), prod,
          model(ra, rb, 32, rsm));
    end

    // Backpressure, and in_valid held high across the DONE->IDLE edge.
    b32.in_valid     = 1'b1;
    b32.multiplicand = 32'd7;
    b32.multiplier   = 32'hFFFF_FFFD;
    b32.signed_mode  = 1'b1;
    cyc();
    b32.in_valid = 1'b0;
    guard = 0;
    while (!b32.out_valid && guard < 40) begin
      cyc();
      guard++;
    end
    chk("bp latency", 64'(guard), 64'd17);
    for (int i = 0; i < 5; i++) begin
      b32.in_valid = 1'b1;
      cyc();
      chk($sformatf("bp hold%0d out_valid", i), 64'(b32.out_valid), 64'd1);
      chk($sformatf("bp hold%0d product", i), b32.product, 64'hFFFF_FFFF_FFFF_FFEB);
    end
    b32.out_ready = 1'b1;
    cyc();
    b32.out_ready = 1'b0;
    b32.in_valid  = 1'b0;
    chk("bp release out_valid", 64'(b32.out_valid), 64'd0);
    chk("bp release in_ready", 64'(b32.in_ready), 64'd1);

    // Reset in the 8th CALC cycle aborts the op and clears the product.
    b32.in_valid     = 1'b1;
    b32.multiplicand = 32'd3;
    b32.multiplier   = 32'd4;
    cyc();
    b32.in_valid = 1'b0;
    repeat (7) cyc();
    chk("calc in_ready", 64'(b32.in_ready), 64'd0);
    chk("calc out_valid", 64'(b32.out_valid), 64'd0);
    rst32 = 1'b1;
    cyc();
    rst32 = 1'b0;
    chk("abort in_ready", 64'(b32.in_ready), 64'd1);
    chk("abort out_valid", 64'(b32.out_valid), 64'd0);
    chk("abort product", b32.product, 64'd0);
    run_op32(32'd5, 32'd6, 1'b1, prod, lat);
    chk("post-abort product", prod, 64'd30);
    chk("post-abort latency", 64'(lat), 64'd17);

    guard = 0;
    while (small_done < 2 && guard < 5000) begin
      cyc();
      guard++;
    end
    if (small_done < 2) chk("small-width runs finished", 64'(small_done), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  for (genvar g = 0; g < 2; g++) begin : g_small
    localparam int unsigned W = 8 << g;
    logic rst_s;

    seq_booth_radix4_multiplier_if #(.WIDTH(W)) ifs ();

    seq_booth_radix4_multiplier #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst_s),
      .bus (ifs)
    );

    initial begin
      logic [63:0] a, b, got;
      logic        sm;
      int          lat;

      ifs.in_valid     = 1'b0;
      ifs.out_ready    = 1'b0;
      ifs.multiplicand = '0;
      ifs.multiplier   = '0;
      ifs.signed_mode  = 1'b0;
      rst_s = 1'b1;
      cyc();
      cyc();
      rst_s = 1'b0;
      chk($sformatf("w%0d reset in_ready", W), 64'(ifs.in_ready), 64'd1);

      for (int i = 0; i < 30; i++) begin
        a  = pick(W);
        b  = pick(W);
        sm = 1'($urandom_range(0, 1));
        ifs.in_valid     = 1'b1;
        ifs.multiplicand = a[W-1:0];
        ifs.multiplier   = b[W-1:0];
        ifs.signed_mode  = sm;
        cyc();
        lat = 0;
        while (!ifs.out_valid && lat < 40) begin
          ifs.in_valid     = 1'($urandom_range(0, 1));
          ifs.multiplicand = W'($urandom);
          ifs.multiplier   = W'($urandom);
          ifs.signed_mode  = 1'($urandom_range(0, 1));
          cyc();
          lat++;
        end
        got = 64'(ifs.product);
        chk($sformatf("w%0d %h*%h s=%0d", W, a, b, sm), got, model(a, b, W, sm));
        chk($sformatf("w%0d latency", W), 64'(lat), 64'(W / 2 + 1));
        ifs.in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) cyc();
        ifs.out_ready = 1'b1;
        cyc();
        ifs.out_ready = 1'b0;
      end
      small_done++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_booth_radix4_multiplier.md
SEQ_BOOTH_RADIX4_MULTIPLIER -- requirements
Module: seq_booth_radix4_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; legal values are even integers >= 4.
REQ-002 SHALL have a single clock domain; reset is synchronous and active-high.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand request.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port multiplicand  input  WIDTH  operand A.
REQ-008 SHALL have port multiplier  input  WIDTH  operand B, Booth-recoded.
REQ-009 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned operands.
REQ-010 SHALL have port out_valid  output  1  product available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts product.
REQ-012 SHALL have port product  output  2*WIDTH  A*B result.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-015 SHALL accept operands on a clock edge with in_valid&&in_ready, then latch multiplicand, multiplier and signed_mode, clear the accumulator, load digit counter=0, and go to CALC.
REQ-016 SHALL ignore in_valid and all operand inputs outside IDLE; latched values govern the operation.
REQ-017 SHALL extend both operands to WIDTH+2 bits: sign-extend when signed_mode=1, zero-extend when 0.
REQ-018 SHALL recode digits from multiplier bits {b[2i+1], b[2i], b[2i-1]} with b[-1]=0, for N = WIDTH/2+1 digits, i = 0..N-1.
REQ-019 SHALL map 000/111 -> 0, 001/010 -> +A, 011 -> +2A, 100 -> -2A, 101/110 -> -A.
REQ-020 SHALL retire exactly one digit per CALC cycle, adding the selected partial product shifted left by 2i into an accumulator of at least 2*WIDTH+4 bits; negation SHALL be two's complement of the extended A.
REQ-021 SHALL go from CALC to DONE after digit N-1, so out_valid rises exactly N clocks after the accepting edge (17 for WIDTH=32).
REQ-022 SHALL drive product from the low 2*WIDTH accumulator bits, and the value SHALL equal the exact mathematical product in the selected mode.
REQ-023 SHALL hold product and out_valid stable in DONE while out_ready=0.
REQ-024 SHALL go from DONE to IDLE on an edge with out_ready=1; in_ready SHALL rise the following cycle, with no same-cycle re-accept.
REQ-025 SHALL hold product at its last value while not in DONE; it is only meaningful when out_valid=1.
REQ-026 SHALL produce a correct result for A or B = 0, the most-negative value, and all-ones in both modes, with no overflow.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, move to IDLE and clear product, the accumulator, the counter and latched operands to 0, giving in_ready=1 and out_valid=0 after that edge.
REQ-028 SHALL give rst priority over every handshake and abort any CALC or DONE operation with no output.
REQ-029 SHALL, after rst deasserts, accept operands on the first edge with in_valid=1.

Verification
REQ-030 SHALL cover WIDTH=32, signed, A=7, B=-3 -> after 17 clocks out_valid=1, product=0xFFFFFFFF_FFFFFFEB.
REQ-031 SHALL cover WIDTH=32, unsigned, A=B=0xFFFFFFFF -> product=0xFFFFFFFE_00000001; the same operands signed -> product=0x00000000_00000001.
REQ-032 SHALL cover WIDTH=32, signed, A=B=0x80000000 -> product=0x40000000_00000000; A=0, B=0x12345678 -> 0.
REQ-033 SHALL cover backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and product stable; out_ready=1 -> IDLE next edge, in_ready=1 the cycle after.
REQ-034 SHALL cover rst asserted on the 8th CALC cycle -> next cycle in_ready=1, out_valid=0, product=0; a new op 5*6 signed then returns 30 after 17 clocks.
REQ-035 SHALL cover WIDTH=8 and WIDTH=16: random signed/unsigned operands against a reference model, plus in_valid toggling and operand changes during CALC -> results unaffected.
